// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides and a 2-entry skid buffer.
// P drives the outputs and S catches one extra op under backpressure.
// in_ready comes straight from a flop, so there is no combinational path
// from out_ready back to in_ready.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal,
    output logic [TAGW-1:0] out_tag,
    output logic [15:0]     op_count
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b101
    } alu_op_e;

    // The state encoding is {p_valid, s_valid}. Both handshake outputs are
    // therefore plain flop bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    // A computed result travels as one word, so its tag and flags cannot
    // drift away from it.
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            illegal;
        logic [TAGW-1:0] tag;
    } res_t;

    state_e state;
    res_t   p_reg;
    res_t   s_reg;
    res_t   alu_res;
    logic   accept;
    logic   deliver;

    assign in_ready  = ~state[0];
    assign out_valid = state[1];
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    assign out_result  = p_reg.result;
    assign out_zero    = p_reg.zero;
    assign out_illegal = p_reg.illegal;
    assign out_tag     = p_reg.tag;

    // Compute the result word for the op presented on the input side.
    always_comb begin
        // NOTE: every field gets a default before the case, so an
        // unlisted op code cannot leave a field unassigned and infer a latch.
        alu_res         = '0;
        alu_res.tag     = in_tag;
        case (alu_op_e'(alu_control))
            OP_ADD:  alu_res.result = src_a + src_b;
            OP_SUB:  alu_res.result = src_a - src_b;
            OP_AND:  alu_res.result = src_a & src_b;
            OP_OR:   alu_res.result = src_a | src_b;
            OP_SLT:  alu_res.result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res.illegal = 1'b1;
        endcase
        alu_res.zero = (alu_res.result == '0);
    end

    // Skid-buffer occupancy and the P/S result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset as well, not only the valid
            // bits, because the outputs must read zero while in reset.
            state <= EMPTY;
            p_reg <= '0;
            s_reg <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // values from before the edge, so S can move into P in the same
            // cycle that P is consumed.
            case (state)
                EMPTY: begin
                    if (accept) begin
                        p_reg <= alu_res;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        p_reg <= alu_res;
                    end else if (accept) begin
                        s_reg <= alu_res;
                        state <= FULL;
                    end else if (deliver) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        p_reg <= s_reg;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Count completed output transfers. The counter wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (deliver) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit. A queue-based reference model holds
// the results that have been accepted but not yet delivered, and the DUT is
// compared against it every cycle. The bench also runs a set of directed ops
// with fixed expected values.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;
    logic [4:0]  out_tag;
    logic [15:0] op_count;

    typedef struct packed {
        logic [31:0] r;
        logic        il;
        logic [4:0]  tag;
    } exp_t;

    exp_t        mq[$];
    logic [4:0]  dtags[$];
    int          checks = 0;
    int          errors = 0;
    int          n_delivered = 0;
    logic [15:0] exp_count = '0;

    alu_exec_unit #(.XLEN(32), .TAGW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_illegal (out_illegal),
        .out_tag     (out_tag),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference ALU, written straight from the op-code table.
    function automatic exp_t ref_alu(input logic [2:0] ctl, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] tag);
        exp_t e;
        int   sa;
        int   sb;
        sa    = int'(a);
        sb    = int'(b);
        e.tag = tag;
        e.il  = 1'b0;
        case (ctl)
            3'd0:    e.r = a + b;
            3'd1:    e.r = a - b;
            3'd2:    e.r = a & b;
            3'd3:    e.r = a | b;
            3'd5:    e.r = (sa < sb) ? 32'd1 : 32'd0;
            default: begin e.r = 32'd0; e.il = 1'b1; end
        endcase
        return e;
    endfunction

    // Run one clock. The task checks the DUT against the model at the negedge,
    // then advances the model at the posedge. It returns #1 after the edge,
    // which is where the caller drives its next inputs.
    task automatic cycle();
        bit acc;
        bit dlv;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("out_result", out_result, mq[0].r);
            check("out_zero", 32'(out_zero), 32'(mq[0].r == 32'd0));
            check("out_illegal", 32'(out_illegal), 32'(mq[0].il));
            check("out_tag", 32'(out_tag), 32'(mq[0].tag));
        end
        check("op_count", 32'(op_count), 32'(exp_count));
        acc = in_valid && (mq.size() < 2);
        dlv = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (dlv) begin
            dtags.push_back(mq[0].tag);
            void'(mq.pop_front());
            exp_count = exp_count + 16'd1;
            n_delivered++;
        end
        if (acc) mq.push_back(ref_alu(alu_control, src_a, src_b, in_tag));
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic ordy);
        in_valid    = v;
        alu_control = ctl;
        src_a       = a;
        src_b       = b;
        in_tag      = tag;
        out_ready   = ordy;
    endtask

    // Send one op into an empty unit, check its fixed expected result just
    // after the accept edge, then drain it.
    task automatic single(input string name, input logic [2:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] er, input logic ez, input logic ei);
        drive(1'b1, ctl, a, b, tag, 1'b1);
        cycle();
        in_valid = 1'b0;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_result"}, out_result, er);
        check({name, "_zero"}, 32'(out_zero), 32'(ez));
        check({name, "_illegal"}, 32'(out_illegal), 32'(ei));
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
        cycle();
    endtask

    initial begin
        logic [15:0] cnt0;
        int          d0;
        bit          rdy_ok;

        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        rst_n = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", out_result, 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed ALU ops.
        single("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd0, 1'b1, 1'b0);
        check("add_wrap_count", 32'(op_count), 32'd1);
        single("sub_eq", 3'b001, 32'd5, 32'd5, 5'd2, 32'd0, 1'b1, 1'b0);
        single("slt_neg", 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd1, 1'b0, 1'b0);
        single("slt_pos", 3'b101, 32'd1, 32'hFFFF_FFFF, 5'd4, 32'd0, 1'b1, 1'b0);
        single("and", 3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5, 32'h00F0_00F0, 1'b0, 1'b0);
        single("or", 3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 32'hFFF0_FFF0, 1'b0, 1'b0);
        cnt0 = op_count;
        single("illegal", 3'b110, 32'd9, 32'd9, 5'd8, 32'd0, 1'b1, 1'b1);
        check("illegal_count", 32'(op_count), 32'(cnt0 + 16'd1));

        // Backpressure: tags 1, 2 and 3 arrive on consecutive cycles while the
        // output is stalled. Tag 3 must be held until the unit has room.
        cnt0 = op_count;
        dtags.delete();
        drive(1'b1, 3'd0, 32'd10, 32'd1, 5'd1, 1'b0);
        cycle();
        drive(1'b1, 3'd1, 32'd10, 32'd1, 5'd2, 1'b0);
        cycle();
        drive(1'b1, 3'd2, 32'd10, 32'd3, 5'd3, 1'b0);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        cycle();
        cycle();
        out_ready = 1'b1;
        while (in_ready == 1'b0) cycle();
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        cycle();
        check("bp_ndeliv", 32'(dtags.size()), 32'd3);
        if (dtags.size() == 3) begin
            check("bp_order0", 32'(dtags[0]), 32'd1);
            check("bp_order1", 32'(dtags[1]), 32'd2);
            check("bp_order2", 32'(dtags[2]), 32'd3);
        end
        check("bp_count", 32'(op_count - cnt0), 32'd3);

        // Full throughput: 20 ops in 20 cycles, with in_ready held high.
        d0     = n_delivered;
        rdy_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 3'($urandom_range(0, 3)), $urandom, $urandom, 5'(i), 1'b1);
            if (in_ready !== 1'b1) rdy_ok = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("tp_in_ready_high", 32'(rdy_ok), 32'd1);
        check("tp_delivered", 32'(n_delivered - d0), 32'd20);

        // Randomised traffic that covers all op codes, with random backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive(1'(($urandom_range(0, 3) != 0)), 3'($urandom_range(0, 7)), a, b,
                  5'($urandom_range(0, 31)), 1'(($urandom_range(0, 2) != 0)));
            cycle();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        cycle();
        cycle();
        cycle();

        // Reset mid-operation: fill the unit, then assert reset between edges.
        drive(1'b1, 3'd0, 32'd1, 32'd2, 5'd11, 1'b0);
        cycle();
        src_a  = 32'd7;
        in_tag = 5'd12;
        cycle();
        check("mid_full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_result", out_result, 32'd0);
        check("mid_rst_zero", 32'(out_zero), 32'd0);
        check("mid_rst_illegal", 32'(out_illegal), 32'd0);
        check("mid_rst_tag", 32'(out_tag), 32'd0);
        check("mid_rst_count", 32'(op_count), 32'd0);
        mq.delete();
        exp_count = '0;
        drive(1'b1, 3'd0, 32'd4, 32'd4, 5'd13, 1'b1);
        @(posedge clk);
        #1;
        check("in_rst_no_accept", 32'(out_valid), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cycle();
        single("post_rst", 3'b000, 32'd2, 32'd3, 5'd9, 32'd5, 1'b0, 1'b0);
        check("post_rst_count", 32'(op_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU for the RISC-V core. It consumes the 3-bit ALU control code and two operands, and returns a registered result with zero and illegal flags. Transfers use valid/ready handshakes on both sides. An internal 2-entry skid buffer gives full throughput under downstream backpressure, and the unit keeps a running count of completed results.

Parameters:
XLEN, 32, operand/result width in bits
TAGW, 5, width of the sideband tag (destination register index) carried with each op

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents an op this cycle
in_ready  output  1  unit can accept an op this cycle
alu_control  input  3  op code: 000 add, 001 sub, 010 and, 011 or, 101 slt; 100/110/111 illegal
src_a  input  XLEN  operand A
src_b  input  XLEN  operand B
in_tag  input  TAGW  sideband tag, returned unchanged with the result
out_valid  output  1  result registers hold a valid result
out_ready  input  1  downstream accepts the result this cycle
out_result  output  XLEN  ALU result
out_zero  output  1  high when out_result == 0 (beq decision)
out_illegal  output  1  the op code was illegal
out_tag  output  TAGW  tag of the presented result
op_count  output  16  number of completed output transfers, wraps modulo 2^16

Behaviour:
- Accept: in_valid & in_ready on a rising edge. Deliver: out_valid & out_ready on a rising edge.
- Arithmetic (combinational on accepted inputs):
  - add/sub: modulo 2^XLEN, carry/borrow discarded.
  - and/or: bitwise.
  - slt: signed two's-complement compare; result = {XLEN-1 zeros, (a<b)}.
- Illegal codes: result 0, out_zero 1, out_illegal 1. The op is still a normal transfer and is counted.
- Latency: an op accepted at edge N is visible on the outputs after edge N (out_valid=1), provided the output register was empty or drained at edge N.
- Storage: a primary output register (P) drives the outputs; a skid register (S) holds one extra computed op. in_ready = ~S_valid, driven directly from a flop with no combinational path from out_ready.
- State machine (encoded as P_valid/S_valid):
  - EMPTY: P and S empty.
    - Accept -> ONE, with P loaded.
  - ONE: P full, S empty.
    - Accept & deliver -> ONE, P reloaded with the new op.
    - Accept, no deliver -> FULL, new op into S.
    - Deliver, no accept -> EMPTY.
    - Neither -> hold.
  - FULL: P and S full; in_ready=0.
    - Deliver -> ONE, S moves to P.
    - Otherwise hold.
- Ordering: results are delivered strictly in acceptance order. Tags and flags always travel with their own result.
- Hold rule: outputs are stable while out_valid=1 and out_ready=0.
- Simultaneous events: in ONE, a same-edge accept and deliver gives no bubble (the result rate is 1 per cycle). In FULL, in_valid is ignored because in_ready=0.
- op_count: increments by 1 on each deliver edge; wraps from 16'hFFFF to 0.
- Reset (rst_n low, any time including mid-operation):
  - Immediately: out_valid=0, out_result=0, out_zero=0, out_illegal=0, out_tag=0, op_count=0; P and S are cleared.
  - in_ready=1 while in reset, but no transfer takes place while rst_n=0.
  - Ops in flight are discarded, not delivered.
  - The first accept can occur on the first rising edge after rst_n goes high.
- Operand and control inputs are don't-care when in_valid=0. Data inputs have no X-propagation requirement when they are not being accepted.

Test Plan:
- Add wrap: add a=32'hFFFF_FFFF, b=1, tag=7, out_ready=1 -> next cycle out_result=0, out_zero=1, out_illegal=0, out_tag=7, op_count=1.
- Sub and slt:
  - sub a=5, b=5 -> result 0, out_zero=1.
  - slt a=32'hFFFF_FFFF (-1), b=1 -> result 1, out_zero=0.
  - slt a=1, b=-1 -> result 0.
  - and/or of 32'hF0F0_F0F0 with 32'h0FF0_0FF0 -> 32'h00F0_00F0 and 32'hFFF0_FFF0 respectively.
- Backpressure: hold out_ready=0 and present tags 1,2,3 on consecutive cycles -> tags 1 and 2 accepted, in_ready=0 on the third cycle and tag 3 is held. Raise out_ready -> results delivered as 1,2,3, in order, with no loss or duplication, and op_count=3.
- Full throughput: in_valid=1 and out_ready=1 for 20 cycles -> 20 results on 20 consecutive cycles after the 1-cycle latency; in_ready stays 1 throughout.
- Illegal code: alu_control=3'b110, a=9, b=9 -> result 0, out_zero=1, out_illegal=1; op_count increments.
- Reset mid-operation: reach FULL, then pulse rst_n low asynchronously between edges -> outputs clear immediately and in_ready=1. After release, no stale result appears; a new op yields its correct result with op_count=1.
